// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: op codes, FSM states and
// carry-select values.
package alu_seq_pkg;

    localparam int unsigned MAX_BYTES_DEF = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    localparam logic [1:0] CSEL_ARITH = 2'b00;
    localparam logic [1:0] CSEL_LOGIC = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/alu_seq_operand_shifter.sv
// Holds the request operands for the duration of an operation and presents the
// currently selected byte; the RHS is stored pre-inverted for subtraction.
module alu_seq_operand_shifter
    import alu_seq_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   invert_i,
    input  logic [8*MAX_BYTES-1:0] lhs_i,
    input  logic [8*MAX_BYTES-1:0] rhs_i,
    input  logic [1:0]             idx_i,
    output logic [7:0]             lhs_byte_o,
    output logic [7:0]             rhs_byte_o
);

    logic [8*MAX_BYTES-1:0] lhs_q;
    logic [8*MAX_BYTES-1:0] rhs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lhs_q <= '0;
            rhs_q <= '0;
        end else if (load_i) begin
            lhs_q <= lhs_i;
            rhs_q <= invert_i ? ~rhs_i : rhs_i;
        end
    end

    assign lhs_byte_o = lhs_q[8*idx_i +: 8];
    assign rhs_byte_o = rhs_q[8*idx_i +: 8];

endmodule

// File: rtl/alu_chain_sequencer.sv
// Sequences a 1-4 byte ALU operation through an external 8-bit ALU, chaining
// carry between bytes and merging the per-byte flags into one response.
module alu_chain_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [1:0]             req_len,
    input  logic [8*MAX_BYTES-1:0] req_lhs,
    input  logic [8*MAX_BYTES-1:0] req_rhs,
    output logic                   alu_issue,
    output logic [2:0]             alu_func,
    output logic [7:0]             alu_lhs,
    output logic [7:0]             alu_rhs,
    output logic                   alu_carry_in,
    output logic [1:0]             alu_carry_sel,
    input  logic [7:0]             alu_result,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    input  logic                   alu_sign,
    input  logic                   alu_ovf,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [8*MAX_BYTES-1:0] resp_data,
    output logic                   resp_carry,
    output logic                   resp_zero,
    output logic                   resp_sign,
    output logic                   resp_ovf
);

    state_e                 state_q;
    logic [2:0]             op_q;
    logic [1:0]             len_q;
    logic [1:0]             idx_q;
    logic [8*MAX_BYTES-1:0] data_q;
    logic                   zero_q;
    logic                   chain_q;
    logic                   carry_q;
    logic                   sign_q;
    logic                   ovf_q;
    logic                   c_flag_q;
    logic                   resp_valid_q;

    logic [7:0] lhs_byte;
    logic [7:0] rhs_byte;
    logic       accept;
    logic       arith;
    logic       issuing;
    logic       first_cin;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign arith     = is_arith(op_q);
    assign issuing   = (state_q == StIssue);

    alu_seq_operand_shifter #(
        .MAX_BYTES (MAX_BYTES)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .invert_i   ((req_op == OP_SUB) || (req_op == OP_SBC)),
        .lhs_i      (req_lhs),
        .rhs_i      (req_rhs),
        .idx_i      (idx_q),
        .lhs_byte_o (lhs_byte),
        .rhs_byte_o (rhs_byte)
    );

    always_comb begin
        first_cin = 1'b0;
        case (op_q)
            OP_ADC, OP_SBC: first_cin = c_flag_q;
            OP_SUB:         first_cin = 1'b1;
            default:        first_cin = 1'b0;
        endcase
    end

    // ALU bus is forced to zero outside the issue cycle.
    always_comb begin
        alu_issue     = issuing;
        alu_func      = OP_ADD;
        alu_lhs       = '0;
        alu_rhs       = '0;
        alu_carry_in  = 1'b0;
        alu_carry_sel = CSEL_ARITH;
        if (issuing) begin
            alu_func      = arith ? OP_ADD : op_q;
            alu_lhs       = lhs_byte;
            alu_rhs       = rhs_byte;
            alu_carry_sel = arith ? CSEL_ARITH : CSEL_LOGIC;
            if (arith) begin
                alu_carry_in = (idx_q == 2'd0) ? first_cin : chain_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= OP_ADD;
            len_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            zero_q       <= 1'b0;
            chain_q      <= 1'b0;
            carry_q      <= 1'b0;
            sign_q       <= 1'b0;
            ovf_q        <= 1'b0;
            c_flag_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q    <= (req_op == OP_RSV) ? OP_ADD : req_op;
                        len_q   <= req_len;
                        idx_q   <= '0;
                        data_q  <= '0;
                        zero_q  <= 1'b1;
                        chain_q <= 1'b0;
                        state_q <= StIssue;
                    end
                end
                StIssue: state_q <= StWait;
                StWait: begin
                    data_q[8*idx_q +: 8] <= alu_result;
                    zero_q               <= zero_q & alu_zero;
                    chain_q              <= alu_carry;
                    if (idx_q == len_q) begin
                        carry_q      <= alu_carry;
                        sign_q       <= alu_sign;
                        ovf_q        <= alu_ovf;
                        c_flag_q     <= alu_carry;
                        resp_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= StIssue;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_carry = carry_q;
    assign resp_zero  = zero_q;
    assign resp_sign  = sign_q;
    assign resp_ovf   = ovf_q;

endmodule
